// File: rtl/uart_frame_serializer_pkg.sv
// uart_frame_serializer_pkg: shared state type, width helpers and defaults for the frame serializer.
package uart_frame_serializer_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam logic [7:0] DEFAULT_HEADER_BASE = 8'hA5;
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        for (r = 0; v > 0; r++) v = v >> 1;
        return r;
    endfunction
    function automatic int min1_width(input int max_value);
        return clogb2(max_value) < 1 ? 1 : clogb2(max_value);
    endfunction
    function automatic int frame_len(input int nbytes, input int header_en, input int csum_en);
        return nbytes + header_en + csum_en;
    endfunction
endpackage

// File: rtl/uart_frame_serializer_rr_arbiter.sv
// rr_arbiter: round-robin grant starting at a registered pointer that advances past each winner.
module rr_arbiter
    import uart_frame_serializer_pkg::*;
#(
    parameter int CH = 2,
    parameter int CW = min1_width(CH - 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] i_req,
    input  logic          i_en,
    input  logic          i_update,
    output logic [CH-1:0] o_grant,
    output logic [CW-1:0] o_idx
);
    logic [CW-1:0] ptr;
    logic found;
    int c;
    always_comb begin
        o_grant = '0;
        o_idx = '0;
        found = 1'b0;
        c = 0;
        for (int i = 0; i < CH; i++) begin
            c = (int'(ptr) + i) % CH;
            if (!found && i_en && i_req[c]) begin
                found = 1'b1;
                o_grant[c] = 1'b1;
                o_idx = CW'(c);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (i_update && found) ptr <= CW'((int'(o_idx) + 1) % CH);
    end
endmodule

// File: rtl/uart_frame_serializer.sv
// uart_frame_serializer: arbitrates channel requests and streams header, payload and XOR checksum
// bytes to a UART transmitter over valid/ready.
module uart_frame_serializer
    import uart_frame_serializer_pkg::*;
#(
    parameter int NBYTES = 10,
    parameter int CH = 2,
    parameter int HEADER_EN = 1,
    parameter logic [7:0] HEADER_BASE = DEFAULT_HEADER_BASE,
    parameter int CSUM_EN = 1,
    localparam int FRAME_LEN = frame_len(NBYTES, HEADER_EN, CSUM_EN),
    localparam int SW = min1_width(FRAME_LEN - 1),
    localparam int CW = min1_width(CH - 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CH-1:0]          i_req,
    input  logic [CH*NBYTES*8-1:0] i_data,
    output logic [CH-1:0]          o_ack,
    output logic [7:0]             o_byte,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [SW-1:0]          o_sel,
    output logic [CW-1:0]          o_ch,
    output logic                   o_busy,
    output logic                   o_done
);
    state_t state, state_n;
    logic [NBYTES*8-1:0] shadow, shadow_n;
    logic [SW-1:0] sel, sel_n;
    logic [CW-1:0] ch, ch_n, idx;
    logic [7:0] csum, csum_n, pay_byte;
    logic [CH-1:0] ack_n, grant;
    logic done_n, idle, xfer, last, is_hdr, is_cs;
    assign idle = state == IDLE;
    assign o_valid = state == SEND;
    assign o_busy = o_valid;
    assign o_sel = sel;
    assign o_ch = ch;
    assign xfer = o_valid && i_ready;
    assign last = int'(sel) == FRAME_LEN - 1;
    assign is_hdr = HEADER_EN != 0 && sel == '0;
    assign is_cs = CSUM_EN != 0 && last;
    rr_arbiter #(.CH(CH)) u_arb (
        .clk(clk),
        .rst(rst),
        .i_req(i_req),
        .i_en(idle),
        .i_update(idle),
        .o_grant(grant),
        .o_idx(idx)
    );
    always_comb begin
        pay_byte = '0;
        for (int b = 0; b < NBYTES; b++)
            if (int'(sel) == b + HEADER_EN) pay_byte = shadow[b*8 +: 8];
    end
    // Gated so the byte lane reads zero whenever nothing is being offered.
    assign o_byte = !o_valid ? 8'h00 : is_hdr ? HEADER_BASE + 8'(ch) : is_cs ? csum : pay_byte;
    always_comb begin
        state_n = state;
        shadow_n = shadow;
        sel_n = sel;
        ch_n = ch;
        csum_n = csum;
        ack_n = '0;
        done_n = 1'b0;
        if (idle && |i_req) begin
            state_n = SEND;
            shadow_n = i_data[int'(idx)*NBYTES*8 +: NBYTES*8];
            sel_n = '0;
            ch_n = idx;
            csum_n = '0;
            ack_n = grant;
        end
        if (xfer) begin
            csum_n = csum ^ o_byte;
            sel_n = last ? '0 : sel + SW'(1);
            state_n = last ? IDLE : SEND;
            done_n = last;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shadow <= '0;
            sel <= '0;
            ch <= '0;
            csum <= '0;
            o_ack <= '0;
            o_done <= 1'b0;
        end else begin
            state <= state_n;
            shadow <= shadow_n;
            sel <= sel_n;
            ch <= ch_n;
            csum <= csum_n;
            o_ack <= ack_n;
            o_done <= done_n;
        end
    end
endmodule

// File: tb/tb_uart_frame_serializer.sv
// tb_uart_frame_serializer: randomized self-checking bench with a frame-level reference model.
module tb_uart_frame_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   req = '0;
    logic [159:0] data = '0;
    logic [1:0]   ack;
    logic [7:0]   obyte;
    logic         valid;
    logic         ready = 1'b0;
    logic [3:0]   sel;
    logic [0:0]   ch_o;
    logic         busy, done;

    logic [0:0] req2 = '0;
    logic [7:0] data2 = '0;
    logic [0:0] ack2;
    logic [7:0] obyte2;
    logic       valid2;
    logic       ready2 = 1'b0;
    logic [0:0] sel2;
    logic [0:0] ch2;
    logic       busy2, done2;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_f [12];

    uart_frame_serializer dut (
        .clk(clk), .rst(rst), .i_req(req), .i_data(data), .o_ack(ack), .o_byte(obyte),
        .o_valid(valid), .i_ready(ready), .o_sel(sel), .o_ch(ch_o), .o_busy(busy), .o_done(done)
    );

    uart_frame_serializer #(.NBYTES(1), .CH(1), .HEADER_EN(0), .CSUM_EN(0)) dut2 (
        .clk(clk), .rst(rst), .i_req(req2), .i_data(data2), .o_ack(ack2), .o_byte(obyte2),
        .o_valid(valid2), .i_ready(ready2), .o_sel(sel2), .o_ch(ch2), .o_busy(busy2), .o_done(done2)
    );

    // Reference frame: header, payload bytes LSB first, then XOR of everything before it.
    task automatic build_frame(input int c, input logic [79:0] pay);
        logic [7:0] x;
        exp_f[0] = 8'hA5 + 8'(c);
        for (int i = 0; i < 10; i++) exp_f[i+1] = pay[i*8 +: 8];
        x = '0;
        for (int i = 0; i < 11; i++) x = x ^ exp_f[i];
        exp_f[11] = x;
    endtask

    task automatic do_reset();
        req = '0;
        req2 = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_data();
        for (int c = 0; c < 2; c++) data[c*80 +: 80] = 80'({$urandom(), $urandom(), $urandom()});
    endtask

    // rmode: 0 ready always high, 1 random, 2 pattern 1,0,0.
    task automatic run_frame(input int c, input int rmode, input bit drop, input bit chg, output int waited);
        int idx, cyc;
        logic r;
        build_frame(c, data[c*80 +: 80]);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!valid && waited < 20);
        checks++;
        if (!valid) begin
            errors++;
            $display("FAIL frame_start ch=%0d: valid never rose within %0d cycles", c, waited);
            return;
        end
        idx = 0;
        cyc = 0;
        while (idx < 12 && cyc < 200) begin
            checks++;
            if (obyte !== exp_f[idx] || sel !== 4'(idx) || busy !== 1'b1 || ch_o !== 1'(c) || done !== 1'b0) begin
                errors++;
                $display("FAIL frame_byte ch=%0d idx=%0d: got byte=%h sel=%0d busy=%b ch=%0d done=%b, want byte=%h sel=%0d busy=1 ch=%0d done=0",
                         c, idx, obyte, sel, busy, ch_o, done, exp_f[idx], idx, c);
            end
            checks++;
            if (ack !== (cyc == 0 ? 2'(1 << c) : 2'b00)) begin
                errors++;
                $display("FAIL ack ch=%0d cyc=%0d: got %b want %b", c, cyc, ack, cyc == 0 ? 2'(1 << c) : 2'b00);
            end
            if (cyc == 0 && drop) req[c] = 1'b0;
            if (cyc == 1 && chg) data[c*80 +: 80] = 80'({$urandom(), $urandom(), $urandom()});
            r = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'(cyc % 3 == 0);
            ready = r;
            if (r) idx++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (idx != 12 || done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || sel !== 4'd0) begin
            errors++;
            $display("FAIL frame_end ch=%0d: sent=%0d done=%b valid=%b busy=%b sel=%0d, want sent=12 done=1 valid=0 busy=0 sel=0",
                     c, idx, done, valid, busy, sel);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ack !== 2'b0 || obyte !== 8'h0 || valid !== 1'b0 || sel !== 4'd0 || ch_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ack=%b byte=%h valid=%b sel=%0d ch=%0d busy=%b done=%b, want all zero",
                     ack, obyte, valid, sel, ch_o, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int w;
        do_reset();
        for (int i = 0; i < 10; i++) data[i*8 +: 8] = 8'(i + 1);
        req = 2'b01;
        run_frame(0, 0, 1'b1, 1'b0, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL single_latency: got %0d want 1", w);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse: done=%b valid=%b want 0 0", done, valid);
        end
    endtask

    task automatic test_backpressure();
        int w;
        do_reset();
        for (int i = 0; i < 10; i++) data[i*8 +: 8] = 8'(i + 1);
        req = 2'b01;
        run_frame(0, 2, 1'b1, 1'b0, w);
    endtask

    task automatic test_contention();
        int w;
        do_reset();
        rand_data();
        req = 2'b11;
        for (int f = 0; f < 3; f++) begin
            run_frame(f % 2, 0, 1'b0, 1'b0, w);
            checks++;
            if (w != 1) begin
                errors++;
                $display("FAIL contention_gap frame=%0d: got %0d want 1", f, w);
            end
        end
        req = 2'b00;
    endtask

    task automatic test_data_change();
        int w;
        do_reset();
        rand_data();
        req = 2'b01;
        run_frame(0, 1, 1'b1, 1'b1, w);
    endtask

    task automatic test_reset_mid();
        int n, w;
        do_reset();
        rand_data();
        req = 2'b01;
        ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(valid && sel == 4'd5) && n < 40);
        checks++;
        if (!(valid && sel == 4'd5)) begin
            errors++;
            $display("FAIL reset_mid_reach: sel=%0d valid=%b want sel=5 valid=1", sel, valid);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 2'b0 || obyte !== 8'h0 || valid !== 1'b0 || sel !== 4'd0 || ch_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state: ack=%b byte=%h valid=%b sel=%0d ch=%0d busy=%b done=%b, want all zero",
                     ack, obyte, valid, sel, ch_o, busy, done);
        end
        rst = 1'b0;
        run_frame(0, 0, 1'b1, 1'b0, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL reset_mid_restart: got latency %0d want 1", w);
        end
    endtask

    task automatic test_random();
        int rr, c, w;
        logic [1:0] mask;
        do_reset();
        rr = 0;
        for (int it = 0; it < 8; it++) begin
            mask = req | 2'($urandom_range(0, 3));
            if (mask == 2'b00) mask = 2'b10;
            rand_data();
            req = mask;
            c = mask[rr] ? rr : 1 - rr;
            run_frame(c, 1, 1'b1, 1'b0, w);
            checks++;
            if (w != 1) begin
                errors++;
                $display("FAIL random_gap it=%0d: got %0d want 1", it, w);
            end
            rr = (c + 1) % 2;
        end
        req = 2'b00;
    endtask

    task automatic test_sweep();
        int n;
        do_reset();
        data2 = 8'h3C;
        req2 = 1'b1;
        ready2 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid2 && n < 20);
        checks++;
        if (valid2 !== 1'b1 || obyte2 !== 8'h3C || sel2 !== 1'b0 || ack2 !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL sweep_byte: valid=%b byte=%h sel=%0d ack=%b busy=%b, want 1 3c 0 1 1",
                     valid2, obyte2, sel2, ack2, busy2);
        end
        req2 = 1'b0;
        @(negedge clk);
        checks++;
        if (done2 !== 1'b1 || valid2 !== 1'b0 || ack2 !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done: done=%b valid=%b ack=%b want 1 0 0", done2, valid2, ack2);
        end
        @(negedge clk);
        checks++;
        if (done2 !== 1'b0 || valid2 !== 1'b0) begin
            errors++;
            $display("FAIL sweep_idle: done=%b valid=%b want 0 0", done2, valid2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_contention();
        test_data_change();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_frame_serializer.md
Name: uart_frame_serializer

Overview:
Multi-channel frame sequencer that feeds a byte-wide UART transmitter. It arbitrates round-robin among CH requesting channels and latches the granted channel's NBYTES-wide payload. It then emits the frame byte-by-byte over a valid/ready handshake: an optional header byte, the payload bytes, and an optional XOR checksum byte. It replaces the single-channel index counter and sits between the event/readout logic and the UART tx core.

Parameters:
NBYTES, 10, payload bytes per frame (>=1)
CH, 2, number of requesting channels (>=1)
HEADER_EN, 1, 1 = prepend header byte
HEADER_BASE, 8'hA5, header value; header byte = (HEADER_BASE + channel index) mod 256
CSUM_EN, 1, 1 = append checksum byte
Derived: FRAME_LEN = NBYTES + HEADER_EN + CSUM_EN; SW = clogb2(FRAME_LEN-1), minimum 1; CW = clogb2(CH-1), minimum 1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_req  in  CH  per-channel frame request, level; held until acked
i_data  in  CH*NBYTES*8  payloads; channel c occupies bits [c*NBYTES*8 +: NBYTES*8]; byte 0 = LSBs
o_ack  out  CH  one-cycle pulse: channel's payload captured
o_byte  out  8  current frame byte
o_valid  out  1  o_byte valid
i_ready  in  1  UART tx accepts byte
o_sel  out  SW  index of current byte within frame
o_ch  out  CW  channel being sent
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse after last byte accepted

Behaviour:
- Reset: state IDLE; all outputs 0; RR pointer 0; shadow payload and checksum cleared. A reset mid-frame aborts the frame: no o_done, and o_ack is not reissued.
- State IDLE:
  - If any i_req bit is set at edge k, grant the first requesting channel at or after the RR pointer, wrapping modulo CH.
  - At edge k, capture that channel's payload into a shadow register, set o_ch, o_sel=0, checksum=0, and move to SEND.
  - o_ack[grant] is high during cycle k+1 only.
  - RR pointer becomes (grant+1) mod CH.
- State SEND:
  - o_valid=1 and o_busy=1 from cycle k+1; first byte is presented in cycle k+1.
  - Byte at index s: header if HEADER_EN and s==0; checksum if CSUM_EN and s==FRAME_LEN-1; otherwise payload byte (s - HEADER_EN).
  - A byte transfers on any edge with o_valid & i_ready. On transfer: checksum ^= o_byte and o_sel increments.
  - The checksum byte equals the XOR of all preceding bytes in the frame, header included.
  - While o_valid & !i_ready, o_byte, o_sel and o_ch hold stable.
  - When the byte at s==FRAME_LEN-1 transfers: go to IDLE, o_valid=0, o_busy=0, o_sel=0, and o_done=1 for the next cycle.
- Back-to-back frames: at least one idle cycle between frames. The new grant is evaluated in the o_done cycle.
- Requests asserted while busy stay pending; a request dropped before grant is ignored. i_data changes after capture have no effect on the frame in flight.
- Simultaneous requests: strict round-robin, no starvation. With CH=1 the pointer is constant 0.
- i_ready is ignored when o_valid=0.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SEND)
  - clogb2 function
  - FRAME_LEN/SW/CW derivations
  - default HEADER_BASE constant
- One sub-module: rr_arbiter. It is parameterised by CH and takes i_req, i_en and i_update. It returns a one-hot grant and a binary index, and holds the registered pointer internally.

Test Plan:
- Single frame, defaults, ready tied 1: ch0 requests payload 0x01..0x0A. Output must be 12 bytes on consecutive cycles: A5,01,02,...,0A,AE. o_sel runs 0..11; o_ack[0] pulses in the first o_valid cycle; o_done pulses once after AE.
- Backpressure: same frame with i_ready toggling 1,0,0,1,... o_byte/o_sel hold during stalls. Byte sequence is unchanged and the checksum is still AE.
- Contention: i_req=2'b11 held. Frames alternate ch0,ch1,ch0; ch1 header is A6. Exactly one idle cycle separates frames; o_ack pulses alternate.
- Data change after capture: alter i_data[ch0] one cycle after o_ack[0]. The transmitted payload is the captured values.
- Reset at byte 5 of a frame: all outputs are 0 the next cycle; no o_done. A held request restarts a full frame from header A5.
- Parameter sweep NBYTES=1, CH=1, HEADER_EN=0, CSUM_EN=0, payload 0x3C: a single byte 3C with o_sel=0, then o_done.
